// File: rtl/axi_axil_rd_split.sv
// AXI4 read slave that splits each burst into single-beat AXI4-Lite reads.
// One burst in flight at a time. Each beat takes one Lite AR handshake and then
// one R handshake. The R channel is passed through combinationally while the
// block waits for the Lite read data.
module axi_axil_rd_split #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state_reg, state_next;
  logic                  arready_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            len_reg;
  logic [7:0]            count_reg;
  logic [2:0]            size_reg;
  logic [1:0]            burst_reg;
  logic [2:0]            prot_reg;

  logic                  ar_hs;
  logic                  r_hs;
  logic                  in_data;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign in_data = (state_reg == DATA);
  assign ar_hs   = (state_reg == IDLE) & arready_reg & s_axi_arvalid;
  assign r_hs    = in_data & m_axil_rvalid & s_axi_rready;

  // Address of the following beat. WRAP keeps the bits above the wrap window
  // and lets only the bits inside the window roll over. The reserved burst
  // type falls into the INCR default.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_reg;
    addr_inc  = addr_reg + step;
    wrap_mask = ((ADDR_WIDTH'(len_reg) + ADDR_WIDTH'(1)) << size_reg) - ADDR_WIDTH'(1);
    case (burst_reg)
      2'b00:   addr_next = addr_reg;
      2'b10:   addr_next = (addr_reg & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_next = addr_inc;
    endcase
  end

  // Next-state logic: IDLE -> ADDR -> DATA, looping back to ADDR until the last beat.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ar_hs) state_next = ADDR;
      ADDR:    if (m_axil_arready) state_next = DATA;
      DATA:    if (r_hs) state_next = (count_reg == 8'd0) ? IDLE : ADDR;
      default: state_next = IDLE;
    endcase
  end

  // State register. arready is registered and tracks whether the next state is IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      arready_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      arready_reg <= (state_next == IDLE);
    end
  end

  // Burst context: captured on AR acceptance and advanced after each returned beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      count_reg <= '0;
      size_reg  <= '0;
      burst_reg <= '0;
      prot_reg  <= '0;
    end else if (ar_hs) begin
      id_reg    <= s_axi_arid;
      addr_reg  <= s_axi_araddr;
      len_reg   <= s_axi_arlen;
      count_reg <= s_axi_arlen;
      size_reg  <= s_axi_arsize;
      burst_reg <= s_axi_arburst;
      prot_reg  <= s_axi_arprot;
    end else if (r_hs && count_reg != 8'd0) begin
      count_reg <= count_reg - 8'd1;
      addr_reg  <= addr_next;
    end
  end

  assign s_axi_arready  = arready_reg;
  assign m_axil_arvalid = (state_reg == ADDR);
  assign m_axil_araddr  = addr_reg;
  assign m_axil_arprot  = prot_reg;

  // R channel is a straight pass-through, opened only while a beat is expected.
  assign s_axi_rvalid  = in_data & m_axil_rvalid;
  assign m_axil_rready = in_data & s_axi_rready;
  assign s_axi_rdata   = m_axil_rdata;
  assign s_axi_rresp   = m_axil_rresp;
  assign s_axi_rid     = id_reg;
  assign s_axi_rlast   = in_data & (count_reg == 8'd0);

endmodule

// File: tb/tb_axi_axil_rd_split.sv
// Directed bench for axi_axil_rd_split. The bench acts as the AXI4 master and
// the AXI4-Lite slave, and checks both sides against hand-computed values.
module tb_axi_axil_rd_split;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_axil_rd_split #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one AR on the AXI4 side; returns one cycle into ADDR.
  task automatic ar_issue(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot);
    @(negedge clk);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arprot = prot;
    s_axi_arvalid = 1'b1;
    #1 check("arready_idle", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    #1 check("arready_busy", s_axi_arready, 1'b0);
  endtask

  // Lite AR phase: address and prot must be held while arready is withheld.
  task automatic addr_phase(input logic [31:0] exp_addr, input logic [2:0] exp_prot, input int wait_cycles);
    check("m_arvalid", m_axil_arvalid, 1'b1);
    check("m_araddr", m_axil_araddr, exp_addr);
    check("m_arprot", m_axil_arprot, exp_prot);
    check("s_rvalid_in_addr", s_axi_rvalid, 1'b0);
    for (int w = 0; w < wait_cycles; w++) begin
      @(negedge clk);
      #1 check("m_araddr_hold", m_axil_araddr, exp_addr);
      check("m_arvalid_hold", m_axil_arvalid, 1'b1);
    end
    m_axil_arready = 1'b1;
    @(negedge clk);
    m_axil_arready = 1'b0;
  endtask

  // Lite R phase, with optional AXI4-side backpressure before the beat is taken.
  task automatic data_phase(input logic [7:0] exp_id, input logic [31:0] data, input logic [1:0] resp,
                            input logic exp_last, input int bp_cycles);
    m_axil_rvalid = 1'b1; m_axil_rdata = data; m_axil_rresp = resp;
    s_axi_rready = (bp_cycles == 0);
    #1 check("m_arvalid_in_data", m_axil_arvalid, 1'b0);
    check("s_rvalid", s_axi_rvalid, 1'b1);
    check("rid", s_axi_rid, exp_id);
    check("rdata", s_axi_rdata, data);
    check("rresp", s_axi_rresp, resp);
    check("rlast", s_axi_rlast, exp_last);
    for (int c = 0; c < bp_cycles; c++) begin
      check("bp_m_rready", m_axil_rready, 1'b0);
      @(negedge clk);
      #1 check("bp_s_rvalid", s_axi_rvalid, 1'b1);
      check("bp_rdata", s_axi_rdata, data);
    end
    s_axi_rready = 1'b1;
    #1 check("m_rready", m_axil_rready, 1'b1);
    @(negedge clk);
    m_axil_rvalid = 1'b0; s_axi_rready = 1'b0;
    #1;
  endtask

  // Full burst of up to four beats; addresses are given by the caller.
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [2:0] prot,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3,
                           input int err_beat, input int bp_beat, input int addr_wait);
    logic [31:0] ea [4];
    logic [31:0] data;
    logic [1:0]  resp;
    ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
    ar_issue(id, addr, len, size, burst, prot);
    for (int b = 0; b <= int'(len); b++) begin
      data = 32'hD000_0000 ^ (ea[b] << 4) ^ 32'(b);
      resp = (b == err_beat) ? 2'b10 : 2'b00;
      addr_phase(ea[b], prot, (b == 0) ? addr_wait : 0);
      data_phase(id, data, resp, b == int'(len), (b == bp_beat) ? 5 : 0);
    end
    check("arready_after_burst", s_axi_arready, 1'b1);
    $display("burst id=0x%0h len=%0d burst=%0b done", id, len, burst);
  endtask

  initial begin
    rst = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    m_axil_arready = 1'b0; m_axil_rdata = '0; m_axil_rresp = '0; m_axil_rvalid = 1'b0;

    #1 check("rst_arready", s_axi_arready, 1'b0);
    check("rst_m_arvalid", m_axil_arvalid, 1'b0);
    check("rst_s_rvalid", s_axi_rvalid, 1'b0);
    check("rst_m_rready", m_axil_rready, 1'b0);
    check("rst_rlast", s_axi_rlast, 1'b0);
    check("rst_rid", s_axi_rid, 8'h00);
    check("rst_araddr", m_axil_araddr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 check("arready_after_rst", s_axi_arready, 1'b1);

    // Single beat.
    run_burst(8'h3C, 32'h40, 8'd0, 3'd2, 2'b01, 3'b010, 32'h40, 32'h0, 32'h0, 32'h0, -1, -1, 0);
    // INCR, backpressure and SLVERR on the second beat.
    run_burst(8'h5A, 32'h100, 8'd3, 3'd2, 2'b01, 3'b001,
              32'h100, 32'h104, 32'h108, 32'h10C, 1, 1, 0);
    // WRAP, with Lite arready withheld on the first beat.
    run_burst(8'h21, 32'h108, 8'd3, 3'd2, 2'b10, 3'b000,
              32'h108, 32'h10C, 32'h100, 32'h104, -1, -1, 2);
    // FIXED.
    run_burst(8'h44, 32'h200, 8'd1, 3'd2, 2'b00, 3'b100, 32'h200, 32'h200, 32'h0, 32'h0, -1, -1, 0);
    // Reserved burst type behaves as INCR; unaligned start is not aligned.
    run_burst(8'h66, 32'h103, 8'd1, 3'd2, 2'b11, 3'b000, 32'h103, 32'h107, 32'h0, 32'h0, -1, -1, 0);

    // Reset during beat 2 of an eight-beat burst.
    ar_issue(8'h77, 32'h300, 8'd7, 3'd2, 2'b01, 3'b000);
    addr_phase(32'h300, 3'b000, 0);
    data_phase(8'h77, 32'hCAFE_0000, 2'b00, 1'b0, 0);
    addr_phase(32'h304, 3'b000, 0);
    m_axil_rvalid = 1'b1; m_axil_rdata = 32'hCAFE_0001; s_axi_rready = 1'b1;
    #1 check("pre_rst_s_rvalid", s_axi_rvalid, 1'b1);
    rst = 1'b0;
    #1 check("mid_rst_s_rvalid", s_axi_rvalid, 1'b0);
    check("mid_rst_m_arvalid", m_axil_arvalid, 1'b0);
    check("mid_rst_m_rready", m_axil_rready, 1'b0);
    check("mid_rst_arready", s_axi_arready, 1'b0);
    check("mid_rst_rlast", s_axi_rlast, 1'b0);
    m_axil_rvalid = 1'b0; s_axi_rready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 check("arready_after_mid_rst", s_axi_arready, 1'b1);
    check("m_arvalid_after_mid_rst", m_axil_arvalid, 1'b0);
    run_burst(8'h12, 32'h80, 8'd0, 3'd2, 2'b01, 3'b000, 32'h80, 32'h0, 32'h0, 32'h0, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
